// File: rtl/idt_issue_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// idt_issue_scheduler_pkg
// Shared types and constants for the issue scheduler and related dispatch
// logic: per-slot lifecycle state, default instruction-buffer size and the
// slot-index width helper.
// ---------------------------------------------------------------------------
package idt_issue_scheduler_pkg;

  localparam int BS_DEFAULT = 16;

  typedef enum logic [1:0] {
    SLOT_FREE    = 2'd0,
    SLOT_WAITING = 2'd1,
    SLOT_ISSUED  = 2'd2
  } slot_state_e;

  // Width of an index into n slots; never less than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/idt_issue_scheduler_rr_priority_pick.sv
// ---------------------------------------------------------------------------
// rr_priority_pick
// Rotating-priority picker: returns the first set request bit found when
// scanning upward from start, wrapping from n-1 back to 0.
//   req    in  n-bit request vector (bit i = requester i)
//   start  in  index where the scan begins (highest priority)
//   found  out at least one request bit is set
//   index  out winning requester (0 when nothing is found)
// ---------------------------------------------------------------------------
module rr_priority_pick
  import idt_issue_scheduler_pkg::*;
#(
  parameter  int n = BS_DEFAULT,
  localparam int W = idx_width(n)
) (
  input  logic [n-1:0] req,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] index
);

  int         pos_i;
  logic [W-1:0] pos;

  // Scan from the lowest priority offset downward so the last hit written is
  // the closest one to start; this avoids a loop break.
  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    found = 1'b0;
    index = '0;
    pos_i = 0;
    pos   = '0;
    for (int k = n - 1; k >= 0; k--) begin
      pos_i = int'(start) + k;
      if (pos_i >= n) pos_i = pos_i - n;
      pos = W'(pos_i);
      if (req[pos]) begin
        found = 1'b1;
        index = pos;
      end
    end
  end

endmodule

// File: rtl/idt_issue_scheduler.sv
// ---------------------------------------------------------------------------
// idt_issue_scheduler
// Holds one dependency row per instruction-buffer slot, marks a slot ready
// once every producer it waits on has completed, and offers one ready slot
// at a time to the execute stage with rotating priority.
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   alloc_valid/index/idt   place an instruction and its dependency vector
//   alloc_ready      target slot is FREE (combinational)
//   issue_valid/index       registered offer of a ready slot
//   issue_ready      downstream accepts the offer
//   complete_valid/index    an issued slot finished execution
//   busy             bit i = slot i not FREE
// ---------------------------------------------------------------------------
module idt_issue_scheduler
  import idt_issue_scheduler_pkg::*;
#(
  parameter  int bs    = BS_DEFAULT,
  localparam int IDX_W = idx_width(bs)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc_valid,
  input  logic [IDX_W-1:0] alloc_index,
  input  logic [bs-1:0]    alloc_idt,
  output logic             alloc_ready,
  output logic             issue_valid,
  output logic [IDX_W-1:0] issue_index,
  input  logic             issue_ready,
  input  logic             complete_valid,
  input  logic [IDX_W-1:0] complete_index,
  output logic [bs-1:0]    busy
);

  slot_state_e      state [bs];
  logic [bs-1:0]    dep   [bs];
  logic [IDX_W-1:0] ptr;

  logic             hs;
  logic             comp_fire;
  logic             alloc_fire;
  logic [bs-1:0]    clr_mask;
  logic [bs-1:0]    hs_mask;
  logic [bs-1:0]    ready;
  logic             pick_found;
  logic [IDX_W-1:0] pick_index;

  always_comb begin
    busy  = '0;
    ready = '0;
    for (int i = 0; i < bs; i++) begin
      busy[i]  = (state[i] != SLOT_FREE);
      ready[i] = (state[i] == SLOT_WAITING) && (dep[i] == '0);
    end
  end

  assign alloc_ready = (state[alloc_index] == SLOT_FREE);
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign hs          = issue_valid && issue_ready;
  // A completing slot is ISSUED, so an allocation aimed at it is rejected.
  assign comp_fire   = complete_valid && (state[complete_index] == SLOT_ISSUED);
  assign clr_mask    = comp_fire ? (bs'(1) << complete_index) : '0;
  // The slot being handshaked is still WAITING this cycle; keep it from
  // being offered a second time.
  assign hs_mask     = hs ? (bs'(1) << issue_index) : '0;

  rr_priority_pick #(.n(bs)) u_pick (
    .req   (ready & ~hs_mask),
    .start (ptr),
    .found (pick_found),
    .index (pick_index)
  );

  // NOTE: the dependency rows are state the ready logic reads straight after
  // reset, so they are cleared by reset rather than left as an unreset RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < bs; i++) begin
        state[i] <= SLOT_FREE;
        dep[i]   <= '0;
      end
      issue_valid <= 1'b0;
      issue_index <= '0;
      ptr         <= '0;
    end else begin
      // NOTE: non-blocking assignments let later statements override earlier
      // ones for the same element (alloc row over the column clear) while all
      // right-hand sides still see pre-edge state.
      for (int i = 0; i < bs; i++) begin
        dep[i] <= dep[i] & ~clr_mask;
      end

      if (hs) begin
        state[issue_index] <= SLOT_ISSUED;
        ptr <= (issue_index == IDX_W'(bs - 1)) ? '0 : issue_index + IDX_W'(1);
      end

      if (comp_fire) begin
        state[complete_index] <= SLOT_FREE;
      end

      // Only live producers are recorded: free slots, the slot itself and a
      // producer completing this very edge are masked out.
      if (alloc_fire) begin
        state[alloc_index] <= SLOT_WAITING;
        dep[alloc_index]   <= alloc_idt & busy & ~(bs'(1) << alloc_index) & ~clr_mask;
      end

      if (!issue_valid || issue_ready) begin
        issue_valid <= pick_found;
        issue_index <= pick_index;
      end
    end
  end

endmodule

// File: tb/tb_idt_issue_scheduler.sv
// ---------------------------------------------------------------------------
// tb_idt_issue_scheduler
// Directed scenarios followed by randomized traffic, all compared against a
// slot-level reference model (per-slot lifecycle plus a list of producers
// each slot still waits on).
// ---------------------------------------------------------------------------
module tb_idt_issue_scheduler;

  localparam int BS = 16;
  localparam int IW = 4;
  localparam int ST_FREE = 0, ST_WAIT = 1, ST_ISS = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          alloc_valid;
  logic [IW-1:0] alloc_index;
  logic [BS-1:0] alloc_idt;
  logic          alloc_ready;
  logic          issue_valid;
  logic [IW-1:0] issue_index;
  logic          issue_ready;
  logic          complete_valid;
  logic [IW-1:0] complete_index;
  logic [BS-1:0] busy;

  idt_issue_scheduler #(.bs(BS)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .alloc_valid    (alloc_valid),
    .alloc_index    (alloc_index),
    .alloc_idt      (alloc_idt),
    .alloc_ready    (alloc_ready),
    .issue_valid    (issue_valid),
    .issue_index    (issue_index),
    .issue_ready    (issue_ready),
    .complete_valid (complete_valid),
    .complete_index (complete_index),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_st   [BS];
  int m_wait [BS][$];   // producers each slot still waits on
  int m_ptr;
  bit m_iv;
  int m_idx;

  function automatic logic [BS-1:0] m_busy();
    logic [BS-1:0] b = '0;
    for (int i = 0; i < BS; i++) b[i] = (m_st[i] != ST_FREE);
    return b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < BS; i++) begin
      m_st[i] = ST_FREE;
      m_wait[i].delete();
    end
    m_ptr = 0;
    m_iv  = 1'b0;
    m_idx = 0;
  endtask

  task automatic model_step(input bit av, input int ai, input logic [BS-1:0] aidt,
                            input bit ir, input bit cv, input int ci);
    bit hs, comp, al, found;
    int pidx, s;
    int nwait[$];
    hs    = m_iv && ir;
    comp  = cv && (m_st[ci] == ST_ISS);
    al    = av && (m_st[ai] == ST_FREE);
    found = 1'b0;
    pidx  = 0;
    if (al) begin
      for (int j = 0; j < BS; j++)
        if (aidt[j] && m_st[j] != ST_FREE && j != ai && !(comp && j == ci))
          nwait.push_back(j);
    end
    for (int k = 0; k < BS; k++) begin
      s = (m_ptr + k) % BS;
      if (!found && m_st[s] == ST_WAIT && m_wait[s].size() == 0 && !(hs && s == m_idx)) begin
        found = 1'b1;
        pidx  = s;
      end
    end
    if (comp) begin
      for (int i = 0; i < BS; i++)
        for (int j = m_wait[i].size() - 1; j >= 0; j--)
          if (m_wait[i][j] == ci) m_wait[i].delete(j);
      m_st[ci] = ST_FREE;
    end
    if (hs) begin
      m_st[m_idx] = ST_ISS;
      m_ptr = (m_idx + 1) % BS;
    end
    if (al) begin
      m_st[ai]   = ST_WAIT;
      m_wait[ai] = nwait;
    end
    if (!m_iv || ir) begin
      m_iv = found;
      if (found) m_idx = pidx;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive_idle();
    alloc_valid    = 1'b0;
    alloc_index    = '0;
    alloc_idt      = '0;
    issue_ready    = 1'b0;
    complete_valid = 1'b0;
    complete_index = '0;
  endtask

  // One clock: drive at negedge, compare, then advance the model at posedge.
  task automatic cycle(input bit av, input int ai, input logic [BS-1:0] aidt,
                       input bit ir, input bit cv, input int ci);
    @(negedge clk);
    alloc_valid    = av;
    alloc_index    = IW'(ai);
    alloc_idt      = aidt;
    issue_ready    = ir;
    complete_valid = cv;
    complete_index = IW'(ci);
    #1;
    check("busy", busy, m_busy());
    check("alloc_ready", alloc_ready, m_st[ai] == ST_FREE);
    check("issue_valid", issue_valid, m_iv);
    if (m_iv) check("issue_index", issue_index, m_idx);
    @(posedge clk);
    model_step(av, ai, aidt, ir, cv, ci);
    #1;
  endtask

  task automatic idle(input bit ir);
    cycle(1'b0, 0, '0, ir, 1'b0, 0);
  endtask

  // Reset pulse landing mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    #2;
    drive_idle();
    rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_issue_valid", issue_valid, 0);
    check("rst_alloc_ready", alloc_ready, 1);
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_hold_busy", busy, 0);
    check("rst_hold_issue_valid", issue_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int iss[$];
    bit av, ir, cv;
    int ai, ci;
    logic [BS-1:0] aidt;

    drive_idle();
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Basic flow: slot 3 with no dependencies.
    cycle(1'b1, 3, 16'h0000, 1'b0, 1'b0, 0);
    idle(1'b0);
    check("basic_offer_v", issue_valid, 1);
    check("basic_offer_idx", issue_index, 3);
    idle(1'b1);
    check("basic_busy3", busy, 16'h0008);
    check("basic_drop_v", issue_valid, 0);
    cycle(1'b0, 0, '0, 1'b0, 1'b1, 3);
    check("basic_free", busy, 16'h0000);

    // RAW chain: slot 1 waits on slot 0.
    cycle(1'b1, 0, 16'h0000, 1'b0, 1'b0, 0);
    cycle(1'b1, 1, 16'h0001, 1'b0, 1'b0, 0);
    check("raw_offer0", issue_index, 0);
    idle(1'b1);
    repeat (3) begin
      idle(1'b1);
      check("raw_blocked", issue_valid, 0);
    end
    cycle(1'b0, 0, '0, 1'b1, 1'b1, 0);
    check("raw_no_bypass", issue_valid, 0);
    idle(1'b0);
    check("raw_offer1_v", issue_valid, 1);
    check("raw_offer1_idx", issue_index, 1);
    idle(1'b1);
    cycle(1'b0, 0, '0, 1'b0, 1'b1, 1);

    // Masking: all-ones idt while nothing else is busy stores an empty row.
    cycle(1'b1, 5, 16'hFFFF, 1'b0, 1'b0, 0);
    cycle(1'b1, 5, 16'h0000, 1'b0, 1'b0, 0);
    check("mask_realloc_blocked", alloc_ready, 0);
    check("mask_offer_v", issue_valid, 1);
    check("mask_offer_idx", issue_index, 5);
    idle(1'b1);
    cycle(1'b0, 0, '0, 1'b0, 1'b1, 5);

    // Backpressure: slot 7 held while slot 2 becomes ready.
    cycle(1'b1, 7, 16'h0000, 1'b0, 1'b0, 0);
    cycle(1'b1, 2, 16'h0000, 1'b0, 1'b0, 0);
    repeat (4) begin
      idle(1'b0);
      check("bp_hold_idx", issue_index, 7);
    end
    idle(1'b1);
    check("bp_next_v", issue_valid, 1);
    check("bp_next_idx", issue_index, 2);
    idle(1'b1);
    cycle(1'b0, 0, '0, 1'b0, 1'b1, 7);
    cycle(1'b0, 0, '0, 1'b0, 1'b1, 2);

    // Rotation from ptr 0: slots 1 and 9.
    @(posedge clk);
    #1;
    do_reset();
    cycle(1'b1, 1, 16'h0000, 1'b0, 1'b0, 0);
    cycle(1'b1, 9, 16'h0000, 1'b0, 1'b0, 0);
    check("rot_first", issue_index, 1);
    idle(1'b1);
    check("rot_second", issue_index, 9);
    idle(1'b1);
    cycle(1'b0, 0, '0, 1'b0, 1'b1, 1);
    cycle(1'b0, 0, '0, 1'b0, 1'b1, 9);
    // ptr is now 10; slots 1 and 12 both ready behind a held offer of 11.
    cycle(1'b1, 11, 16'h0000, 1'b0, 1'b0, 0);
    cycle(1'b1, 1, 16'h0000, 1'b0, 1'b0, 0);
    cycle(1'b1, 12, 16'h0000, 1'b0, 1'b0, 0);
    idle(1'b1);
    check("rot_wrap_first", issue_index, 12);
    idle(1'b1);
    check("rot_wrap_second", issue_index, 1);
    idle(1'b1);
    cycle(1'b0, 0, '0, 1'b0, 1'b1, 11);
    cycle(1'b0, 0, '0, 1'b0, 1'b1, 12);
    cycle(1'b0, 0, '0, 1'b0, 1'b1, 1);

    // Randomized traffic with a reset in the middle.
    for (int n = 0; n < 1500; n++) begin
      if (n == 700) begin
        @(posedge clk);
        #1;
        do_reset();
      end
      av   = ($urandom_range(0, 1) == 1);
      ai   = $urandom_range(0, BS - 1);
      aidt = BS'($urandom & $urandom & $urandom);
      ir   = ($urandom_range(0, 9) < 7);
      iss.delete();
      for (int i = 0; i < BS; i++) if (m_st[i] == ST_ISS) iss.push_back(i);
      if (iss.size() > 0 && $urandom_range(0, 9) < 6) begin
        cv = 1'b1;
        ci = iss[$urandom_range(0, iss.size() - 1)];
      end else begin
        cv = ($urandom_range(0, 3) == 0);
        ci = $urandom_range(0, BS - 1);
      end
      cycle(av, ai, aidt, ir, cv, ci);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
